rsp_s1_prep_div: RTL and testbench
==================================

# rsp_s1_prep_div

Iterative radix-2 divider for the s1 preparation path, forming the inverse arithmetic stage next to the pipelined multiplier. It accepts a dividend/divisor pair through a valid/ready handshake and runs a restoring shift-subtract loop. It returns the quotient and remainder with a fixed latency, in unsigned or signed (TC) mode. Results are held until the consumer takes them.

## Interface
- A_width, 8: dividend and quotient width; must satisfy A_width >= B_width >= 2
- B_width, 8: divisor and remainder width
- CLK  input  1  rising-edge clock
- RST  input  1  asynchronous, active-high reset
- IN_VALID  input  1  operand pair valid
- IN_READY  output  1  divider idle, can accept operands
- A  input  A_width  dividend
- B  input  B_width  divisor
- TC  input  1  0: unsigned, 1: two's-complement signed; sampled with A/B
- OUT_VALID  output  1  result valid
- OUT_READY  input  1  consumer accepts result
- QUOTIENT  output  A_width  quotient
- REMAINDER  output  B_width  remainder
- DIV_BY_0  output  1  divisor was zero for this result

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - IN_READY=1.
  - On IN_VALID: latch TC, the operand signs and the magnitudes |A|,|B|. Magnitudes are taken only when TC=1, otherwise the raw values are used.
  - Clear the partial remainder, set the iteration counter to A_width-1, and go to CALC.
- CALC: one quotient bit per cycle, MSB first.
  - The partial remainder (B_width+1 bits) shifts in the next dividend bit.
  - If the partial remainder >= |B|: subtract |B| and set the quotient bit to 1.
  - The counter decrements. After bit 0, go to FIX.
- FIX: sign correction when TC=1.
  - Negate the quotient when sign(A) xor sign(B).
  - Negate the remainder when sign(A)=1.
  - The result truncates toward zero, and the remainder takes the sign of the dividend.
  - Write the QUOTIENT, REMAINDER and DIV_BY_0 registers and go to DONE.
- Divide by zero (B==0):
  - The loop still runs, so latency is unchanged.
  - FIX forces QUOTIENT = all ones, REMAINDER = A[B_width-1:0] and DIV_BY_0=1.
- Signed overflow (TC=1, A = -2^(A_width-1), B = -1): QUOTIENT = A, REMAINDER = 0. This falls out naturally from the unsigned core plus negation.
- DONE: OUT_VALID=1. On OUT_READY, go to IDLE.
- Output stability: all outputs are registered and stay stable while OUT_VALID=1 and OUT_READY=0. A, B, TC and IN_VALID are ignored outside IDLE.

## Timing
- Reset values: state IDLE, IN_READY=1, OUT_VALID=0, QUOTIENT=0, REMAINDER=0, DIV_BY_0=0. The partial remainder and counter are also cleared.
- Accept: operands are taken at the rising edge where IN_VALID=1 and IN_READY=1. IN_READY goes low after that edge.
- Latency: OUT_VALID rises after edge A_width+1 counted from the accept edge. That is 9 edges for A_width=8, independent of operand values.
- Release: OUT_VALID falls, and IN_READY rises, at the edge where OUT_VALID=1 and OUT_READY=1.
- Throughput: the next accept is possible no earlier than the following edge. The minimum initiation interval is A_width+3 cycles.
- Reset mid-operation: RST asserted in any state forces the reset values asynchronously. The in-flight operation is discarded with no OUT_VALID pulse, and operation restarts in IDLE after RST deasserts.
- Unused handshake: OUT_READY held high while in IDLE/CALC/FIX has no effect.

## Configuration
- RSP_S1_DIV_REM_EN: remainder path.
  - Defined: REMAINDER is computed, sign-corrected and registered as described above.
  - Undefined:
    - The remainder output register and its negation logic are removed, and REMAINDER is tied to 0.
    - The divide-by-zero remainder is also 0.
    - Quotient, DIV_BY_0, latency and handshake are unchanged.

## Test plan
- Unsigned, A_width=B_width=8, TC=0, A=200, B=7.
  - Required: QUOTIENT=28, REMAINDER=4, DIV_BY_0=0.
  - OUT_VALID rises exactly 9 edges after accept.
- Signed, TC=1, A=0xF9 (-7), B=0x02.
  - Required: QUOTIENT=0xFD (-3), REMAINDER=0xFF (-1).
  - Also A=0x07, B=0xFE: QUOTIENT=0xFD, REMAINDER=0x01.
- Divide by zero, A=0x55, B=0x00, TC=0 and TC=1.
  - Required: QUOTIENT=0xFF, REMAINDER=0x55, DIV_BY_0=1, same latency.
  - Without RSP_S1_DIV_REM_EN: REMAINDER=0.
- Signed overflow, TC=1, A=0x80, B=0xFF.
  - Required: QUOTIENT=0x80, REMAINDER=0x00, DIV_BY_0=0.
- Backpressure: OUT_READY held low for 5 cycles after OUT_VALID, with A/B/IN_VALID toggled meanwhile.
  - Required: outputs unchanged and IN_READY=0 throughout.
  - Release completes at the first OUT_READY=1 edge, and a second op is accepted on the next edge.
- Reset mid-CALC: assert RST 4 cycles after accept.
  - Required: outputs return to reset values immediately and no OUT_VALID pulse occurs.
  - A new op, 100/10, then returns Q=10, R=0.

Source files
------------

// File: rtl/rsp_s1_prep_div.sv
// -----------------------------------------------------------------------------
// rsp_s1_prep_div
//
// Iterative radix-2 restoring divider for the s1 preparation path. It takes one
// dividend/divisor pair through a valid/ready handshake and produces one
// quotient bit per cycle, MSB first. Unsigned or two's-complement signed
// operation is selected per operation with TC. The result is held until the
// consumer takes it.
//
// Latency: OUT_VALID rises after edge A_width+1, counted from the accept edge.
// Minimum initiation interval: A_width+3 cycles.
//
// Optional feature macro:
//   RSP_S1_DIV_REM_EN  - defined: REMAINDER is computed, sign-corrected and
//                        registered. Undefined: REMAINDER is tied to 0.
//
// Parameters:
//   A_width    dividend / quotient width (A_width >= B_width >= 2)
//   B_width    divisor / remainder width
//
// Ports:
//   CLK        rising-edge clock
//   RST        asynchronous active-high reset
//   IN_VALID   operand pair valid
//   IN_READY   divider idle, can accept operands
//   A          dividend
//   B          divisor
//   TC         0: unsigned, 1: signed; sampled together with A/B
//   OUT_VALID  result valid
//   OUT_READY  consumer accepts result
//   QUOTIENT   quotient (truncated toward zero)
//   REMAINDER  remainder (takes the sign of the dividend)
//   DIV_BY_0   divisor was zero for this result
// -----------------------------------------------------------------------------
module rsp_s1_prep_div #(
   parameter int A_width = 8,
   parameter int B_width = 8
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               IN_VALID,
   output logic               IN_READY,
   input  logic [A_width-1:0] A,
   input  logic [B_width-1:0] B,
   input  logic               TC,
   output logic               OUT_VALID,
   input  logic               OUT_READY,
   output logic [A_width-1:0] QUOTIENT,
   output logic [B_width-1:0] REMAINDER,
   output logic               DIV_BY_0
);

   localparam int CNT_W = (A_width > 2) ? $clog2(A_width) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_FIX  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   logic [1:0]         state;
   logic               tc_r;
   logic               a_neg;
   logic               b_neg;
   logic [A_width-1:0] dvd;      // dividend magnitude, shifted out MSB first; quotient shifts in at the LSB
   logic [B_width-1:0] bmag;     // divisor magnitude
   logic [B_width:0]   pr;       // partial remainder
   logic [CNT_W-1:0]   cnt;

   logic signed [A_width-1:0] a_s;
   logic signed [B_width-1:0] b_s;

   logic [B_width:0]   pr_sh;
   logic [B_width:0]   pr_sub;
   logic               q_bit;

`ifdef RSP_S1_DIV_REM_EN
   logic [B_width-1:0] a_low;    // raw low dividend bits, returned as the divide-by-zero remainder
`endif

   function automatic logic [A_width-1:0] neg_a(input logic [A_width-1:0] v);
      return -v;
   endfunction

   function automatic logic [B_width-1:0] neg_b(input logic [B_width-1:0] v);
      return -v;
   endfunction

   assign a_s = A;
   assign b_s = B;

   // Restoring step. pr[B_width] can only be set if the previous step left a
   // remainder >= 2^B_width, which the loop never does; folding it into the
   // compare keeps the step correct for the full partial-remainder width.
   always_comb begin
      pr_sh  = {pr[B_width-1:0], dvd[A_width-1]};
      q_bit  = pr[B_width] | (pr_sh >= {1'b0, bmag});
      pr_sub = pr_sh - {1'b0, bmag};
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state     <= S_IDLE;
         IN_READY  <= 1'b1;
         OUT_VALID <= 1'b0;
         QUOTIENT  <= '0;
         DIV_BY_0  <= 1'b0;
         tc_r      <= 1'b0;
         a_neg     <= 1'b0;
         b_neg     <= 1'b0;
         dvd       <= '0;
         bmag      <= '0;
         pr        <= '0;
         cnt       <= '0;
`ifdef RSP_S1_DIV_REM_EN
         REMAINDER <= '0;
         a_low     <= '0;
`endif
      end else begin
         case (state)
            // IDLE: accept operands, capture signs and magnitudes
            S_IDLE: begin
               if (IN_VALID) begin
                  tc_r     <= TC;
                  a_neg    <= a_s < 0;
                  b_neg    <= b_s < 0;
                  dvd      <= (TC && (a_s < 0)) ? neg_a(A) : A;
                  bmag     <= (TC && (b_s < 0)) ? neg_b(B) : B;
                  pr       <= '0;
                  cnt      <= CNT_W'(A_width - 1);
                  IN_READY <= 1'b0;
                  state    <= S_CALC;
`ifdef RSP_S1_DIV_REM_EN
                  a_low    <= A[B_width-1:0];
`endif
               end
            end
            // CALC: one quotient bit per cycle
            S_CALC: begin
               pr  <= q_bit ? pr_sub : pr_sh;
               dvd <= {dvd[A_width-2:0], q_bit};
               cnt <= cnt - CNT_W'(1);
               if (cnt == '0) begin
                  state <= S_FIX;
               end
            end
            // FIX: sign correction and divide-by-zero override
            S_FIX: begin
               if (bmag == '0) begin
                  QUOTIENT  <= '1;
                  DIV_BY_0  <= 1'b1;
`ifdef RSP_S1_DIV_REM_EN
                  REMAINDER <= a_low;
`endif
               end else begin
                  QUOTIENT  <= (tc_r && (a_neg ^ b_neg)) ? neg_a(dvd) : dvd;
                  DIV_BY_0  <= 1'b0;
`ifdef RSP_S1_DIV_REM_EN
                  REMAINDER <= (tc_r && a_neg) ? neg_b(pr[B_width-1:0]) : pr[B_width-1:0];
`endif
               end
               OUT_VALID <= 1'b1;
               state     <= S_DONE;
            end
            // DONE: hold result until taken
            S_DONE: begin
               if (OUT_READY) begin
                  OUT_VALID <= 1'b0;
                  IN_READY  <= 1'b1;
                  state     <= S_IDLE;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

`ifndef RSP_S1_DIV_REM_EN
   assign REMAINDER = '0;
`endif

endmodule

// File: tb/tb_rsp_s1_prep_div.sv
// -----------------------------------------------------------------------------
// tb_rsp_s1_prep_div
//
// Directed self-checking bench for rsp_s1_prep_div with A_width=B_width=8.
// Expected remainders follow the RSP_S1_DIV_REM_EN build option.
// -----------------------------------------------------------------------------
module tb_rsp_s1_prep_div;

   logic       CLK;
   logic       RST;
   logic       IN_VALID;
   logic       IN_READY;
   logic [7:0] A;
   logic [7:0] B;
   logic       TC;
   logic       OUT_VALID;
   logic       OUT_READY;
   logic [7:0] QUOTIENT;
   logic [7:0] REMAINDER;
   logic       DIV_BY_0;

   int n_cmp = 0;
   int n_bad = 0;

   rsp_s1_prep_div #(.A_width(8), .B_width(8)) dut (
      .CLK      (CLK),
      .RST      (RST),
      .IN_VALID (IN_VALID),
      .IN_READY (IN_READY),
      .A        (A),
      .B        (B),
      .TC       (TC),
      .OUT_VALID(OUT_VALID),
      .OUT_READY(OUT_READY),
      .QUOTIENT (QUOTIENT),
      .REMAINDER(REMAINDER),
      .DIV_BY_0 (DIV_BY_0)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   function automatic logic [7:0] rem_exp(input logic [7:0] r);
`ifdef RSP_S1_DIV_REM_EN
      return r;
`else
      return (r & 8'h00);
`endif
   endfunction

   // Present one operand pair, let it be accepted, and count edges from the
   // accept edge until OUT_VALID is seen; lat = -1 if it never comes.
   task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic tc, output int lat);
      @(negedge CLK);
      A = a; B = b; TC = tc; IN_VALID = 1'b1;
      @(posedge CLK);
      #1;
      IN_VALID = 1'b0;
      lat = -1;
      for (int i = 1; i <= 40; i++) begin
         @(posedge CLK);
         #1;
         if (OUT_VALID === 1'b1) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic take_result();
      OUT_READY = 1'b1;
      @(posedge CLK);
      #1;
      OUT_READY = 1'b0;
   endtask

   task automatic test_reset();
      RST = 1'b1;
      @(posedge CLK);
      #1;
      n_cmp++; if (IN_READY !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", IN_READY); end
      n_cmp++; if (OUT_VALID !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", OUT_VALID); end
      n_cmp++; if (QUOTIENT !== 8'h00) begin n_bad++; $display("FAIL reset_quotient: got %h want 00", QUOTIENT); end
      n_cmp++; if (REMAINDER !== 8'h00) begin n_bad++; $display("FAIL reset_remainder: got %h want 00", REMAINDER); end
      n_cmp++; if (DIV_BY_0 !== 1'b0) begin n_bad++; $display("FAIL reset_div_by_0: got %b want 0", DIV_BY_0); end
      @(negedge CLK);
      RST = 1'b0;
   endtask

   task automatic test_unsigned();
      int lat;
      do_op(8'd200, 8'd7, 1'b0, lat);
      n_cmp++; if (lat !== 9) begin n_bad++; $display("FAIL unsigned_latency: got %0d want 9", lat); end
      n_cmp++; if (QUOTIENT !== 8'd28) begin n_bad++; $display("FAIL unsigned_quotient: got %0d want 28", QUOTIENT); end
      n_cmp++; if (REMAINDER !== rem_exp(8'd4)) begin n_bad++; $display("FAIL unsigned_remainder: got %0d want %0d", REMAINDER, rem_exp(8'd4)); end
      n_cmp++; if (DIV_BY_0 !== 1'b0) begin n_bad++; $display("FAIL unsigned_div_by_0: got %b want 0", DIV_BY_0); end
      n_cmp++; if (IN_READY !== 1'b0) begin n_bad++; $display("FAIL unsigned_busy_in_ready: got %b want 0", IN_READY); end
      take_result();
      n_cmp++; if (OUT_VALID !== 1'b0) begin n_bad++; $display("FAIL unsigned_release_valid: got %b want 0", OUT_VALID); end
      n_cmp++; if (IN_READY !== 1'b1) begin n_bad++; $display("FAIL unsigned_release_ready: got %b want 1", IN_READY); end
   endtask

   task automatic test_signed();
      int lat;
      do_op(8'hF9, 8'h02, 1'b1, lat);
      n_cmp++; if (lat !== 9) begin n_bad++; $display("FAIL signed1_latency: got %0d want 9", lat); end
      n_cmp++; if (QUOTIENT !== 8'hFD) begin n_bad++; $display("FAIL signed1_quotient: got %h want fd", QUOTIENT); end
      n_cmp++; if (REMAINDER !== rem_exp(8'hFF)) begin n_bad++; $display("FAIL signed1_remainder: got %h want %h", REMAINDER, rem_exp(8'hFF)); end
      take_result();
      do_op(8'h07, 8'hFE, 1'b1, lat);
      n_cmp++; if (lat !== 9) begin n_bad++; $display("FAIL signed2_latency: got %0d want 9", lat); end
      n_cmp++; if (QUOTIENT !== 8'hFD) begin n_bad++; $display("FAIL signed2_quotient: got %h want fd", QUOTIENT); end
      n_cmp++; if (REMAINDER !== rem_exp(8'h01)) begin n_bad++; $display("FAIL signed2_remainder: got %h want %h", REMAINDER, rem_exp(8'h01)); end
      take_result();
   endtask

   task automatic test_div0();
      int lat;
      for (int t = 0; t < 2; t++) begin
         do_op(8'h55, 8'h00, t[0], lat);
         n_cmp++; if (lat !== 9) begin n_bad++; $display("FAIL div0_tc%0d_latency: got %0d want 9", t, lat); end
         n_cmp++; if (QUOTIENT !== 8'hFF) begin n_bad++; $display("FAIL div0_tc%0d_quotient: got %h want ff", t, QUOTIENT); end
         n_cmp++; if (REMAINDER !== rem_exp(8'h55)) begin n_bad++; $display("FAIL div0_tc%0d_remainder: got %h want %h", t, REMAINDER, rem_exp(8'h55)); end
         n_cmp++; if (DIV_BY_0 !== 1'b1) begin n_bad++; $display("FAIL div0_tc%0d_flag: got %b want 1", t, DIV_BY_0); end
         take_result();
      end
   endtask

   task automatic test_overflow();
      int lat;
      do_op(8'h80, 8'hFF, 1'b1, lat);
      n_cmp++; if (lat !== 9) begin n_bad++; $display("FAIL overflow_latency: got %0d want 9", lat); end
      n_cmp++; if (QUOTIENT !== 8'h80) begin n_bad++; $display("FAIL overflow_quotient: got %h want 80", QUOTIENT); end
      n_cmp++; if (REMAINDER !== 8'h00) begin n_bad++; $display("FAIL overflow_remainder: got %h want 00", REMAINDER); end
      n_cmp++; if (DIV_BY_0 !== 1'b0) begin n_bad++; $display("FAIL overflow_div_by_0: got %b want 0", DIV_BY_0); end
      take_result();
   endtask

   task automatic test_back_to_back();
      int lat;
      logic [18:0] held;
      do_op(8'd60, 8'd7, 1'b0, lat);
      n_cmp++; if (lat !== 9) begin n_bad++; $display("FAIL bp_latency: got %0d want 9", lat); end
      held = {1'b1, 1'b0, 1'b0, 8'd8, rem_exp(8'd4)};
      for (int c = 0; c < 5; c++) begin
         @(negedge CLK);
         IN_VALID = ~IN_VALID;
         A = 8'h11 * 8'(c + 1);
         B = 8'h0F + 8'(c);
         TC = c[0];
         @(posedge CLK);
         #1;
         n_cmp++;
         if ({OUT_VALID, IN_READY, DIV_BY_0, QUOTIENT, REMAINDER} !== held) begin
            n_bad++;
            $display("FAIL bp_hold_cycle%0d: got v%b r%b d%b q%h rem%h want v1 r0 d0 q08 rem%h",
                     c, OUT_VALID, IN_READY, DIV_BY_0, QUOTIENT, REMAINDER, rem_exp(8'd4));
         end
      end
      @(negedge CLK);
      IN_VALID = 1'b0;
      OUT_READY = 1'b1;
      @(posedge CLK);
      #1;
      OUT_READY = 1'b0;
      n_cmp++; if (OUT_VALID !== 1'b0) begin n_bad++; $display("FAIL bp_release_valid: got %b want 0", OUT_VALID); end
      n_cmp++; if (IN_READY !== 1'b1) begin n_bad++; $display("FAIL bp_release_ready: got %b want 1", IN_READY); end
      // The second op is presented for the very next edge.
      do_op(8'd100, 8'd3, 1'b0, lat);
      n_cmp++; if (lat !== 9) begin n_bad++; $display("FAIL b2b_latency: got %0d want 9", lat); end
      n_cmp++; if (QUOTIENT !== 8'd33) begin n_bad++; $display("FAIL b2b_quotient: got %0d want 33", QUOTIENT); end
      n_cmp++; if (REMAINDER !== rem_exp(8'd1)) begin n_bad++; $display("FAIL b2b_remainder: got %0d want %0d", REMAINDER, rem_exp(8'd1)); end
      // Result is left pending; the reset test discards it.
   endtask

   task automatic test_reset_mid_calc();
      int lat;
      int pulses;
      take_result();
      @(negedge CLK);
      A = 8'd200; B = 8'd7; TC = 1'b0; IN_VALID = 1'b1;
      @(posedge CLK);
      #1;
      IN_VALID = 1'b0;
      repeat (4) @(posedge CLK);
      #1;
      RST = 1'b1;
      #1;
      n_cmp++; if (IN_READY !== 1'b1) begin n_bad++; $display("FAIL rst_mid_in_ready: got %b want 1", IN_READY); end
      n_cmp++; if (OUT_VALID !== 1'b0) begin n_bad++; $display("FAIL rst_mid_out_valid: got %b want 0", OUT_VALID); end
      n_cmp++; if (QUOTIENT !== 8'h00) begin n_bad++; $display("FAIL rst_mid_quotient: got %h want 00", QUOTIENT); end
      n_cmp++; if (REMAINDER !== 8'h00) begin n_bad++; $display("FAIL rst_mid_remainder: got %h want 00", REMAINDER); end
      n_cmp++; if (DIV_BY_0 !== 1'b0) begin n_bad++; $display("FAIL rst_mid_div_by_0: got %b want 0", DIV_BY_0); end
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      RST = 1'b0;
      pulses = 0;
      for (int c = 0; c < 15; c++) begin
         @(posedge CLK);
         #1;
         if (OUT_VALID === 1'b1) pulses++;
      end
      n_cmp++; if (pulses !== 0) begin n_bad++; $display("FAIL rst_mid_no_pulse: got %0d valid cycles want 0", pulses); end
      do_op(8'd100, 8'd10, 1'b0, lat);
      n_cmp++; if (lat !== 9) begin n_bad++; $display("FAIL rst_after_latency: got %0d want 9", lat); end
      n_cmp++; if (QUOTIENT !== 8'd10) begin n_bad++; $display("FAIL rst_after_quotient: got %0d want 10", QUOTIENT); end
      n_cmp++; if (REMAINDER !== 8'd0) begin n_bad++; $display("FAIL rst_after_remainder: got %0d want 0", REMAINDER); end
      take_result();
   endtask

   initial begin
      RST = 1'b1;
      IN_VALID = 1'b0;
      A = 8'h00;
      B = 8'h00;
      TC = 1'b0;
      OUT_READY = 1'b0;
      test_reset();
      test_unsigned();
      test_signed();
      test_div0();
      test_overflow();
      test_back_to_back();
      test_reset_mid_calc();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
